// File: rtl/dmem_pkg.sv
// dmem_pkg: FSM state encoding, word size and bus direction constants for data_mem_resp.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
    localparam int WORD_BYTES = 4;
    localparam logic LOAD = 1'b1;
    localparam logic STORE = 1'b0;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port DEPTH_WORDS x 32 RAM, synchronous read and write, no reset.
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            else rdata_q <= mem_q[addr_i];
        end
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: three-state data memory responder; one access per IDLE->ACCESS->RESP pass.
// Optional address range/alignment checking via `define DMEM_ERR_CHECK_EN.
module data_mem_resp
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic        we_in,
    output logic [31:0] load_data_out,
    output logic        ack_out,
    output logic        busy_out,
    output logic        err_out
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_e        state_q, state_d;
    logic [31:0]   addr_q, wdata_q, load_q, ram_rdata;
    logic          we_q, addr_err, load_ok;
    logic [AW-1:0] idx;
    assign idx = AW'((addr_q - BASE_ADDR) >> 2);
`ifdef DMEM_ERR_CHECK_EN
    localparam logic [32:0] SPAN = 33'(WORD_BYTES) * 33'(DEPTH_WORDS);
    logic [32:0] off;
    // Addresses below the base borrow into bit 32, so one compare covers both ends.
    assign off = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    assign addr_err = (addr_q[1:0] != 2'b00) || (off >= SPAN);
`else
    assign addr_err = 1'b0;
`endif
    assign load_ok = (we_q == LOAD) && !addr_err;
    always_comb begin
        state_d = (state_q == IDLE) ? (req_in ? ACCESS : IDLE) :
                  (state_q == ACCESS) ? RESP : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_in) begin
                addr_q  <= addr_in;
                wdata_q <= store_data_in;
                we_q    <= we_in;
            end
            if (state_q == RESP && load_ok) load_q <= ram_rdata;
        end
    end
    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk     (clk),
        .en_i    (state_q == ACCESS && !addr_err),
        .we_i    (we_q == STORE),
        .addr_i  (idx),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );
    // The RAM output register presents the load word from the RESP edge; load_q holds it afterwards.
    assign load_data_out = (state_q == RESP && load_ok) ? ram_rdata : load_q;
    assign ack_out       = (state_q == RESP);
    assign busy_out      = (state_q != IDLE);
    assign err_out       = ack_out && addr_err;
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: directed vectors against a transaction-level model of data_mem_resp.
module tb_data_mem_resp;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic        LD = 1'b1, ST = 1'b0;
    logic        clk = 0, rst_n = 0, req = 0, we = 0;
    logic [31:0] addr = 0, sdata = 0;
    logic [31:0] dout;
    logic        ack, busy, err;
    int vectors = 0, miscompares = 0;
    always #5 clk = ~clk;
    data_mem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst_n), .req_in(req), .addr_in(addr), .store_data_in(sdata),
        .we_in(we), .load_data_out(dout), .ack_out(ack), .busy_out(busy), .err_out(err)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: a transaction is accepted only when idle, takes effect one edge later, then one idle edge.
    logic [31:0] mdl_mem [DEPTH];
    int          phase = 0;
    logic [31:0] m_addr = 0, m_data = 0, m_last = 0;
    logic        m_we = 0, m_err = 0;
    function automatic logic bad(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
        return (a[1:0] != 2'b00) || (a < BASE) || ((longint'(a) - longint'(BASE)) >= 4 * DEPTH);
`else
        return 1'b0;
`endif
    endfunction
    function automatic int widx(input logic [31:0] a);
        return int'(((a - BASE) >> 2) % DEPTH);
    endfunction
    always @(posedge clk) begin
        if (rst_n) begin
            if (phase == 0) begin
                if (req) begin
                    m_addr = addr; m_data = sdata; m_we = we; phase = 1;
                end
            end else if (phase == 1) begin
                phase = 2;
                m_err = bad(m_addr);
                if (!m_err) begin
                    if (m_we == LD) m_last = mdl_mem[widx(m_addr)];
                    else mdl_mem[widx(m_addr)] = m_data;
                end
            end else phase = 0;
        end
    end
    always @(negedge rst_n) begin
        phase = 0; m_last = 0;
    end
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(busy), 32'(phase != 0));
            check("ack", 32'(ack), 32'(phase == 2));
            check("err", 32'(err), 32'(phase == 2 && m_err));
            check("load_data", dout, m_last);
        end
    end
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                        output logic [31:0] rd, output logic e);
        int n = 0;
        req = 1; addr = a; sdata = d; we = w;
        @(negedge clk);
        req = 0;
        while (!ack && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("ack_seen", 32'(ack), 32'd1);
        rd = dout; e = err;
        @(negedge clk);
    endtask
    task automatic reset_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_data"}, dout, 32'd0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [31:0] rd;
        logic        e;
        int          acks;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 0;
        #1 reset_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        xfer(32'h10, 32'hDEAD_BEEF, ST, rd, e);
        xfer(32'h10, 32'h0, LD, rd, e);
        check("lit_deadbeef", rd, 32'hDEAD_BEEF);
        check("lit_deadbeef_err", 32'(e), 32'd0);
        xfer(32'h40, 32'h1111_1111, ST, rd, e);
        req = 1; addr = 32'h44; sdata = 32'h2222_2222; we = ST;
        @(negedge clk);
        check("lit_n1_busy", 32'(busy), 32'd1);
        check("lit_n1_ack", 32'(ack), 32'd0);
        addr = 32'h40; sdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("lit_n2_ack", 32'(ack), 32'd1);
        @(negedge clk);
        check("lit_n3_busy", 32'(busy), 32'd0);
        req = 0;
        @(negedge clk);
        xfer(32'h40, 32'h0, LD, rd, e);
        check("lit_ignored_req", rd, 32'h1111_1111);
        xfer(32'h44, 32'h0, LD, rd, e);
        check("lit_captured_req", rd, 32'h2222_2222);
        acks = 0;
        req = 1; addr = 32'h10; we = LD;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        req = 0;
        @(negedge clk);
        check("lit_b2b_acks", 32'(acks), 32'd2);
        xfer(32'h20, 32'h0BAD_F00D, ST, rd, e);
        req = 1; addr = 32'h20; sdata = 32'h1234_5678; we = ST;
        @(negedge clk);
        req = 0;
        #2 rst_n = 0;
        #1 reset_zero("abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        xfer(32'h20, 32'h0, LD, rd, e);
        check("lit_abort_kept", rd, 32'h0BAD_F00D);
        xfer(32'h13, 32'h0, LD, rd, e);
`ifdef DMEM_ERR_CHECK_EN
        check("lit_unaligned_err", 32'(e), 32'd1);
        check("lit_unaligned_hold", rd, 32'h0BAD_F00D);
        xfer(32'h1000, 32'hA5A5_A5A5, ST, rd, e);
        check("lit_range_err", 32'(e), 32'd1);
`else
        check("lit_unaligned_err", 32'(e), 32'd0);
        check("lit_unaligned_word", rd, 32'hDEAD_BEEF);
        xfer(32'h1000, 32'hA5A5_A5A5, ST, rd, e);
        xfer(32'h0, 32'h0, LD, rd, e);
        check("lit_wrap", rd, 32'hA5A5_A5A5);
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
